// File: rtl/mem_lsu.sv
// Memory-access stage: single-outstanding data-bus handshake plus registered write-back triple.
// Optional misaligned-access rejection is enabled by defining MEM_MISALIGN_CHECK_EN.
module mem_lsu #(
    parameter int REQ_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  memop_i,
    input  logic [31:0] maddr_i,
    input  logic [31:0] mdata_i,
    output logic        stall_o,
    output logic        dbus_req_o,
    output logic        dbus_we_o,
    output logic [31:0] dbus_addr_o,
    output logic [31:0] dbus_wdata_o,
    output logic [3:0]  dbus_be_o,
    input  logic        dbus_ack_i,
    input  logic [31:0] dbus_rdata_i,
    output logic        valid_o,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        bus_err_o,
    output logic        misalign_o,
    output logic        state_dbg
);
    // Handshake: dbus_req_o stays high with stable dbus_* until the cycle dbus_ack_i is seen
    // (read data sampled in that same cycle), or until timeout/reset.
    localparam logic [3:0] OP_LB = 4'b0001, OP_LH = 4'b0010, OP_LW = 4'b0011,
                           OP_LBU = 4'b0100, OP_LHU = 4'b0101,
                           OP_SB = 4'b1000, OP_SH = 4'b1001, OP_SW = 4'b1010;
    localparam int CW = (REQ_TIMEOUT < 2) ? 1 : $clog2(REQ_TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(REQ_TIMEOUT - 1);

    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;
    state_t state, state_nx;

    logic [CW-1:0] cnt;
    logic [3:0]    op_q;
    logic [1:0]    a_q;
    logic [4:0]    wd_q;
    logic          wreg_q;
    logic          is_mem, is_store, mis_in, accept, acked, timeout;
    logic [3:0]    be_nx;
    logic [31:0]   st_data, ld_data;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;

    always_comb begin
        is_mem   = 1'b0;
        is_store = 1'b0;
        case (memop_i)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: is_mem = 1'b1;
            OP_SB, OP_SH, OP_SW: begin
                is_mem   = 1'b1;
                is_store = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef MEM_MISALIGN_CHECK_EN
    always_comb begin
        mis_in = 1'b0;
        case (memop_i)
            OP_LH, OP_LHU, OP_SH: mis_in = maddr_i[0];
            OP_LW, OP_SW:         mis_in = |maddr_i[1:0];
            default: ;
        endcase
    end
`else
    assign mis_in = 1'b0;
`endif

    assign accept  = (state == S_IDLE) && valid_i && is_mem && !mis_in;
    assign acked   = (state == S_BUSY) && dbus_ack_i;
    assign timeout = (state == S_BUSY) && !dbus_ack_i && (REQ_TIMEOUT != 0) && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (accept) state_nx = S_BUSY;
            S_BUSY: if (acked || timeout) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        stall_o   = accept || ((state == S_BUSY) && !dbus_ack_i);
        state_dbg = state;
    end

    // Store lane steering for the op being accepted; loads enable all four lanes.
    always_comb begin
        be_nx   = 4'b1111;
        st_data = mdata_i;
        case (memop_i)
            OP_SB: begin
                be_nx   = 4'b0001 << maddr_i[1:0];
                st_data = {4{mdata_i[7:0]}};
            end
            OP_SH: begin
                be_nx   = maddr_i[1] ? 4'b1100 : 4'b0011;
                st_data = {2{mdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (a_q)
            2'd0:    ld_byte = dbus_rdata_i[7:0];
            2'd1:    ld_byte = dbus_rdata_i[15:8];
            2'd2:    ld_byte = dbus_rdata_i[23:16];
            default: ld_byte = dbus_rdata_i[31:24];
        endcase
        ld_half = a_q[1] ? dbus_rdata_i[31:16] : dbus_rdata_i[15:0];
        case (op_q)
            OP_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  ld_data = {24'b0, ld_byte};
            OP_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  ld_data = {16'b0, ld_half};
            default: ld_data = dbus_rdata_i;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dbus_req_o <= 1'b0; dbus_we_o <= 1'b0; dbus_addr_o <= '0;
            dbus_wdata_o <= '0; dbus_be_o <= '0;
            valid_o <= 1'b0; wd_o <= '0; wreg_o <= 1'b0; wdata_o <= '0;
            bus_err_o <= 1'b0; misalign_o <= 1'b0;
            cnt <= '0; op_q <= '0; a_q <= '0; wd_q <= '0; wreg_q <= 1'b0;
        end else begin
            bus_err_o  <= 1'b0;
            misalign_o <= 1'b0;
            if (state == S_IDLE) begin
                if (accept) begin
                    op_q <= memop_i; a_q <= maddr_i[1:0]; wd_q <= wd_i; wreg_q <= wreg_i;
                    dbus_req_o   <= 1'b1;
                    dbus_we_o    <= is_store;
                    dbus_addr_o  <= {maddr_i[31:2], 2'b00};
                    dbus_wdata_o <= st_data;
                    dbus_be_o    <= be_nx;
                    cnt          <= '0;
                    valid_o      <= 1'b0;
                    wreg_o       <= 1'b0;
                end else if (valid_i && is_mem) begin
                    valid_o    <= 1'b1;
                    wd_o       <= wd_i;
                    wreg_o     <= 1'b0;
                    wdata_o    <= wdata_i;
                    misalign_o <= 1'b1;
                end else if (valid_i) begin
                    valid_o <= 1'b1;
                    wd_o    <= wd_i;
                    wreg_o  <= wreg_i;
                    wdata_o <= wdata_i;
                end else begin
                    valid_o <= 1'b0;
                    wreg_o  <= 1'b0;
                end
            end else if (acked) begin
                dbus_req_o <= 1'b0;
                valid_o    <= 1'b1;
                wd_o       <= wd_q;
                wreg_o     <= dbus_we_o ? 1'b0 : wreg_q;
                wdata_o    <= dbus_we_o ? 32'b0 : ld_data;
            end else if (timeout) begin
                dbus_req_o <= 1'b0;
                bus_err_o  <= 1'b1;
                valid_o    <= 1'b1;
                wd_o       <= wd_q;
                wreg_o     <= 1'b0;
                wdata_o    <= '0;
            end else begin
                cnt     <= cnt + 1'b1;
                valid_o <= 1'b0;
            end
        end
    end
endmodule
